// File: rtl/pong_game_ctrl.sv
// Pong game controller: tick divider, serve timing, scoring and win detection.
// Optional feature macro: PONG_PAUSE_EN (start edge in PLAY pauses the game).
module pong_game_ctrl #(
  parameter int unsigned TICK_DIV    = 524288,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned X_GOAL_L    = 10,
  parameter int unsigned X_GOAL_R    = 610
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] posx,
  output logic       ball_tick,
  output logic       ball_load,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = $clog2(SERVE_DELAY + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
`ifdef PONG_PAUSE_EN
    OVER  = 3'd4,
    PAUSE = 3'd5
`else
    OVER  = 3'd4
`endif
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   div_q;
  logic [SW-1:0]   serve_q;
  logic            start_q;
  logic [3:0]      score_l_q;
  logic [3:0]      score_r_q;
  logic [1:0]      winner_q;
  logic            serve_dir_q;
  logic            ball_load_q;

  logic            tick;
  logic            start_edge;
  logic            goal_l;
  logic            goal_r;

  assign tick       = (div_q == DW'(TICK_DIV - 1));
  assign start_edge = start & ~start_q;
  assign goal_l     = (posx <= 10'(X_GOAL_L));
  assign goal_r     = (posx >= 10'(X_GOAL_R));

  // Free-running game-tick divider and start-button sampler.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      start_q <= 1'b0;
    end else begin
      div_q   <= tick ? '0 : div_q + 1'b1;
      start_q <= start;
    end
  end

  // Game FSM with registered scores, winner, serve direction and ball hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      serve_q     <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= 2'b00;
      serve_dir_q <= 1'b0;
      ball_load_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE, OVER: begin
          ball_load_q <= 1'b1;
          if (start_edge) begin
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 2'b00;
            serve_q   <= '0;
            state_q   <= SERVE;
          end
        end
        SERVE: begin
          ball_load_q <= 1'b1;
          if (tick) begin
            if (serve_q == SW'(SERVE_DELAY - 1)) begin
              serve_q     <= '0;
              ball_load_q <= 1'b0;
              state_q     <= PLAY;
            end else begin
              serve_q <= serve_q + 1'b1;
            end
          end
        end
        PLAY: begin
          ball_load_q <= 1'b0;
          // Left goal is tested first so it wins when both limits are met.
          if (goal_l) begin
            if (score_r_q != 4'(WIN_SCORE)) score_r_q <= score_r_q + 1'b1;
            serve_dir_q <= 1'b1;
            ball_load_q <= 1'b1;
            state_q     <= POINT;
          end else if (goal_r) begin
            if (score_l_q != 4'(WIN_SCORE)) score_l_q <= score_l_q + 1'b1;
            serve_dir_q <= 1'b0;
            ball_load_q <= 1'b1;
            state_q     <= POINT;
          end
`ifdef PONG_PAUSE_EN
          else if (start_edge) begin
            state_q <= PAUSE;
          end
`endif
        end
        POINT: begin
          ball_load_q <= 1'b1;
          if (score_l_q == 4'(WIN_SCORE)) begin
            winner_q <= 2'b01;
            state_q  <= OVER;
          end else if (score_r_q == 4'(WIN_SCORE)) begin
            winner_q <= 2'b10;
            state_q  <= OVER;
          end else begin
            state_q  <= SERVE;
          end
        end
`ifdef PONG_PAUSE_EN
        PAUSE: begin
          ball_load_q <= 1'b0;
          if (start_edge) state_q <= PLAY;
        end
`endif
        default: begin
          ball_load_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign ball_tick = (state_q == PLAY) && tick;
  assign ball_load = ball_load_q;
  assign serve_dir = serve_dir_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with TICK_DIV=4, SERVE_DELAY=2, WIN_SCORE=2.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] posx;
  logic       ball_tick;
  logic       ball_load;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] winner;
  logic [2:0] state;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc_n = 0;

  pong_game_ctrl #(
    .TICK_DIV(4),
    .SERVE_DELAY(2),
    .WIN_SCORE(2),
    .X_GOAL_L(10),
    .X_GOAL_R(610)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .posx(posx),
    .ball_tick(ball_tick),
    .ball_load(ball_load),
    .serve_dir(serve_dir),
    .score_l(score_l),
    .score_r(score_r),
    .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  // Edge count since the last reset edge; the divider phase is cyc_n % 4.
  always @(posedge clk) cyc_n <= rst ? 0 : cyc_n + 1;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int unsigned maxc);
    int unsigned n = 0;
    while (state !== s && n < maxc) begin
      cyc(1);
      n++;
    end
    check(tag, int'(state), int'(s));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_score_l"}, score_l, 0);
    check({tag, "_score_r"}, score_r, 0);
    check({tag, "_winner"}, winner, 0);
    check({tag, "_serve_dir"}, serve_dir, 0);
    check({tag, "_ball_tick"}, ball_tick, 0);
    check({tag, "_ball_load"}, ball_load, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned entries;
    int unsigned ticks_seen;
    logic [2:0]  prev;

    rst   = 1'b1;
    start = 1'b0;
    posx  = 10'd320;
    cyc(3);
    check_reset_vals("reset");
    rst = 1'b0;

    // Start edge lands on the edge where the divider wraps to 0.
    cyc(3);
    start = 1'b1;
    cyc(1);
    check("serve_enter", state, 1);
    check("serve_load", ball_load, 1);
    cyc(4);
    check("serve_mid", state, 1);
    start = 1'b0;
    cyc(3);
    check("serve_last", state, 1);
    check("serve_last_load", ball_load, 1);
    cyc(1);
    check("play_enter", state, 2);
    check("play_load", ball_load, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      check($sformatf("ball_tick_%0d", i), ball_tick, ((i % 4) == 3) ? 1 : 0);
    end

    posx = 10'd10;
    cyc(1);
    check("goal_l_score_r", score_r, 1);
    check("goal_l_score_l", score_l, 0);
    check("goal_l_dir", serve_dir, 1);
    check("goal_l_state", state, 3);
    check("goal_l_tick", ball_tick, 0);
    posx = 10'd320;
    cyc(1);
    check("point_to_serve", state, 1);
    check("point_load", ball_load, 1);

    wait_state("rally2_play", 3'd2, 20);
    posx = 10'd620;
    cyc(1);
    check("goal_r_score_l", score_l, 1);
    check("goal_r_dir", serve_dir, 0);
    check("goal_r_state", state, 3);
    posx = 10'd320;
    cyc(1);
    check("point2_serve", state, 1);

    wait_state("rally3_play", 3'd2, 20);
    posx = 10'd620;
    cyc(1);
    check("goal3_score_l", score_l, 2);
    check("goal3_state", state, 3);
    cyc(1);
    check("over_state", state, 4);
    check("over_winner", winner, 1);
    check("over_load", ball_load, 1);
    for (int i = 0; i < 6; i++) begin
      posx = (i % 2 == 0) ? 10'd620 : 10'd5;
      cyc(1);
      check("over_hold_score_l", score_l, 2);
      check("over_hold_score_r", score_r, 1);
      check("over_hold_tick", ball_tick, 0);
      check("over_hold_state", state, 4);
    end
    posx = 10'd320;

    start = 1'b1;
    cyc(1);
    check("restart_state", state, 1);
    check("restart_score_l", score_l, 0);
    check("restart_score_r", score_r, 0);
    check("restart_winner", winner, 0);
    start = 1'b0;

    wait_state("rally4_play", 3'd2, 20);
    posx = 10'd10;
    cyc(1);
    check("goal4_score_r", score_r, 1);
    posx = 10'd320;
    cyc(1);
    check("goal4_serve", state, 1);
    check("goal4_dir", serve_dir, 1);

    // Advance to the first tick inside SERVE: serve counter is then 1.
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (cyc_n % 4 == 0) break;
    end
    check("serve_cnt1_state", state, 1);
    rst = 1'b1;
    cyc(1);
    check_reset_vals("mid_serve_reset");
    rst = 1'b0;

    start   = 1'b1;
    entries = 0;
    prev    = state;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (state == 3'd1 && prev != 3'd1) entries++;
      prev = state;
    end
    check("held_start_entries", entries, 1);
    check("held_start_play", state, 2);
    start = 1'b0;

`ifdef PONG_PAUSE_EN
    wait_state("pause_pre_play", 3'd2, 20);
    cyc(1);
    start = 1'b1;
    cyc(1);
    check("pause_enter", state, 5);
    start = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (ball_tick) ticks_seen++;
    end
    check("pause_no_tick", ticks_seen, 0);
    check("pause_hold", state, 5);
    start = 1'b1;
    cyc(1);
    check("pause_exit", state, 2);
    start = 1'b0;
`else
    wait_state("nopause_pre_play", 3'd2, 20);
    cyc(1);
    start = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (ball_tick) ticks_seen++;
    end
    check("nopause_state", state, 2);
    check("nopause_ticks", ticks_seen, 2);
    start = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
